// File: rtl/pu_controller.sv
// pu_controller: sequencer for the four-lane processing unit.
// On start it issues `count` weight rows (one per cycle), tracks each row
// through the fixed PU latency with a valid shift register, writes each
// ReLU result to the result buffer in issue order, then pulses done.
//
// Ports:
//   clk      in   system clock (rising edge)
//   rst      in   synchronous active-high reset
//   start    in   launch request, sampled only in IDLE
//   count    in   number of rows, sampled with start
//   wBase    in   first weight row address, sampled with start
//   resBase  in   first result address, sampled with start
//   wAddr    out  weight memory read address (asynchronous read)
//   enReg    out  PU input register block enable
//   resAddr  out  result buffer write address
//   resWr    out  result buffer write strobe
//   busy     out  high while issuing or draining
//   done     out  one-cycle completion pulse
module pu_controller #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] count,
  input  logic [ADDR_W-1:0] wBase,
  input  logic [ADDR_W-1:0] resBase,
  output logic [ADDR_W-1:0] wAddr,
  output logic              enReg,
  output logic [ADDR_W-1:0] resAddr,
  output logic              resWr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cnt, w_base, res_base;
  logic [ADDR_W-1:0]   idx, wr_idx;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [PIPE_LAT-1:0] vld;
  logic                issue, last_issue, last_write, launch;

  always_comb begin
    issue      = (state == ISSUE);
    launch     = (state == IDLE) && start && (count != '0);
    last_issue = (idx == cnt - ADDR_W'(1));
    last_write = vld[PIPE_LAT-1] && (wr_idx == cnt - ADDR_W'(1));
  end

  // Next state and outputs
  always_comb begin
    state_n = state;
    enReg   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    wAddr   = w_addr_q;
    resWr   = vld[PIPE_LAT-1];
    resAddr = res_base + wr_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        enReg = 1'b1;
        busy  = 1'b1;
        wAddr = w_base + idx;
        if (last_issue) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_write) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      w_base   <= '0;
      res_base <= '0;
      idx      <= '0;
      wr_idx   <= '0;
      w_addr_q <= '0;
      vld      <= '0;
    end else begin
      state <= state_n;
      // Concatenate-then-truncate shifts `issue` in at bit 0 and stays
      // legal when PIPE_LAT is 1.
      vld   <= PIPE_LAT'({vld, issue});
      if (launch) begin
        cnt      <= count;
        w_base   <= wBase;
        res_base <= resBase;
        idx      <= '0;
        wr_idx   <= '0;
      end
      if (issue) begin
        idx      <= idx + ADDR_W'(1);
        w_addr_q <= w_base + idx;
      end
      if (vld[PIPE_LAT-1]) begin
        wr_idx <= wr_idx + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pu_controller.sv
module tb_pu_controller;

  localparam int unsigned AW  = 6;
  localparam int unsigned PL0 = 3;
  localparam int unsigned PL1 = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start0, start1;
  logic [AW-1:0] count, wBase, resBase;

  logic [AW-1:0] wAddr0, resAddr0, wAddr1, resAddr1;
  logic          enReg0, resWr0, busy0, done0;
  logic          enReg1, resWr1, busy1, done1;

  always #5 clk = ~clk;

  pu_controller #(.ADDR_W(AW), .PIPE_LAT(PL0)) dut (
    .clk(clk), .rst(rst), .start(start0), .count(count), .wBase(wBase),
    .resBase(resBase), .wAddr(wAddr0), .enReg(enReg0), .resAddr(resAddr0),
    .resWr(resWr0), .busy(busy0), .done(done0)
  );

  pu_controller #(.ADDR_W(AW), .PIPE_LAT(PL1)) dut_lat1 (
    .clk(clk), .rst(rst), .start(start1), .count(count), .wBase(wBase),
    .resBase(resBase), .wAddr(wAddr1), .enReg(enReg1), .resAddr(resAddr1),
    .resWr(resWr1), .busy(busy1), .done(done1)
  );

  // Weight memory and PU model: multipliers -> input registers (enReg)
  // -> two registered adder levels -> ReLU, giving a 3-cycle latency.
  logic signed [7:0]  wmem [64][4];
  logic signed [7:0]  xs   [4];
  logic signed [15:0] p    [4];
  logic signed [15:0] s1a, s1b, s2;
  logic [15:0]        result;

  always @(posedge clk) begin
    if (enReg0) begin
      for (int j = 0; j < 4; j++) p[j] <= wmem[wAddr0][j] * xs[j];
    end
    s1a <= p[0] + p[1];
    s1b <= p[2] + p[3];
    s2  <= s1a + s1b;
  end
  assign result = (s2 < 0) ? 16'd0 : s2;

  typedef struct {
    int unsigned cnt;
    logic [AW-1:0] wb;
    logic [AW-1:0] rb;
    bit sel;   // 0: PIPE_LAT=3 unit, 1: PIPE_LAT=1 unit
    bit hold;  // keep start high into ISSUE
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    bit            chk_data;
  } exp_t;

  exp_t sb[$];
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  function automatic logic [15:0] row_result(logic [AW-1:0] a);
    logic signed [15:0] s;
    s = '0;
    for (int j = 0; j < 4; j++) s += wmem[a][j] * xs[j];
    return (s < 0) ? 16'd0 : s;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " wAddr"},   32'(wAddr0),   0);
    check({tag, " enReg"},   32'(enReg0),   0);
    check({tag, " resAddr"}, 32'(resAddr0), 0);
    check({tag, " resWr"},   32'(resWr0),   0);
    check({tag, " busy"},    32'(busy0),    0);
    check({tag, " done"},    32'(done0),    0);
  endtask

  task automatic run_case(input vec_t v);
    int unsigned   pl, dcyc;
    logic [AW-1:0] ea, o_wa, o_ra;
    logic          o_en, o_wr, o_busy, o_done;
    exp_t          e;
    string         tg;
    pl   = v.sel ? PL1 : PL0;
    dcyc = (v.cnt == 0) ? 1 : v.cnt + pl + 1;
    @(posedge clk); #1;
    count   = AW'(v.cnt);
    wBase   = v.wb;
    resBase = v.rb;
    if (v.sel) start1 = 1'b1; else start0 = 1'b1;
    for (int unsigned i = 0; i < v.cnt; i++) begin
      e.addr     = v.rb + AW'(i);
      e.data     = row_result(v.wb + AW'(i));
      e.chk_data = !v.sel;
      sb.push_back(e);
    end
    for (int unsigned c = 1; c <= dcyc + 1; c++) begin
      @(posedge clk); #1;
      if (v.hold && c == 1) begin
        count = AW'(2);
        wBase = '0;
      end
      if (!v.hold || c >= 3) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      o_wa   = v.sel ? wAddr1   : wAddr0;
      o_ra   = v.sel ? resAddr1 : resAddr0;
      o_en   = v.sel ? enReg1   : enReg0;
      o_wr   = v.sel ? resWr1   : resWr0;
      o_busy = v.sel ? busy1    : busy0;
      o_done = v.sel ? done1    : done0;
      tg = $sformatf("n%0d/c%0d", v.cnt, c);
      check({tg, " enReg"}, 32'(o_en), 32'(c <= v.cnt));
      if (c <= v.cnt) begin
        ea = v.wb + AW'(c - 1);
        check({tg, " wAddr"}, 32'(o_wa), 32'(ea));
      end else if (v.cnt > 0 && c <= v.cnt + pl) begin
        ea = v.wb + AW'(v.cnt - 1);
        check({tg, " wAddr hold"}, 32'(o_wa), 32'(ea));
      end
      check({tg, " busy"}, 32'(o_busy), 32'(v.cnt > 0 && c <= v.cnt + pl));
      check({tg, " done"}, 32'(o_done), 32'(c == dcyc));
      check({tg, " resWr"}, 32'(o_wr),
            32'(v.cnt > 0 && c >= 1 + pl && c <= v.cnt + pl));
      if (o_wr) begin
        if (sb.size() == 0) begin
          check({tg, " unexpected write"}, 1, 0);
        end else begin
          e = sb.pop_front();
          check({tg, " resAddr"}, 32'(o_ra), 32'(e.addr));
          if (e.chk_data) check({tg, " result"}, 32'(result), 32'(e.data));
        end
      end
    end
    check($sformatf("n%0d writes outstanding", v.cnt), sb.size(), 0);
    sb.delete();
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 6'd5,  6'd9,  1'b0, 1'b0};  // single row
    vecs[1] = '{8, 6'd0,  6'd32, 1'b0, 1'b0};  // burst with negative row
    vecs[2] = '{4, 6'd62, 6'd63, 1'b0, 1'b0};  // address wrap
    vecs[3] = '{0, 6'd7,  6'd7,  1'b0, 1'b0};  // zero count
    vecs[4] = '{5, 6'd10, 6'd20, 1'b0, 1'b1};  // start held during ISSUE
    vecs[5] = '{3, 6'd7,  6'd11, 1'b1, 1'b0};  // PIPE_LAT=1 unit

    for (int a = 0; a < 64; a++) begin
      wmem[a][0] = 8'sd3;
      wmem[a][1] = 8'sd2;
      wmem[a][2] = -8'sd1;
      wmem[a][3] = 8'sd4;
    end
    wmem[5][0] = -8'sd3;
    wmem[5][1] = -8'sd2;
    wmem[5][2] = 8'sd1;
    wmem[5][3] = -8'sd4;
    for (int j = 0; j < 4; j++) xs[j] = 8'sd1;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    count = '0; wBase = '0; resBase = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset busy lat1", 32'(busy1), 0);
    check("reset resWr lat1", 32'(resWr1), 0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) run_case(vecs[k]);

    // Reset in cycle 3 of a count=6 run aborts rows already in flight.
    @(posedge clk); #1;
    count = AW'(6); wBase = AW'(3); resBase = AW'(40); start0 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
      check($sformatf("abort c%0d enReg", c), 32'(enReg0), 1);
    end
    rst = 1'b1;
    for (int c = 4; c <= 12; c++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      check_zero($sformatf("abort c%0d", c));
    end
    run_case('{2, 6'd20, 6'd50, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pu_controller.md
# pu_controller

Sequencer for the four-lane processing unit (4 multipliers -> input register block -> registered adder tree -> ReLU). On a `start` pulse it streams `count` weight rows from weight memory into the unit, one row per cycle, by driving the weight read address and the register-block enable. It tracks each issued row through the fixed pipeline latency and writes every ReLU result to the result buffer at the matching address. It then pulses `done`.

## Interface
Parameters:
- `ADDR_W`, 6: width of the weight and result addresses and of `count`.
- `PIPE_LAT`, 3: cycles from the `enReg` cycle of a row to the cycle its `result` is valid; legal range 1..8.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `count`  in  ADDR_W  number of rows to process; sampled with `start`.
- `wBase`  in  ADDR_W  first weight-row address; sampled with `start`.
- `resBase`  in  ADDR_W  first result address; sampled with `start`.
- `wAddr`  out  ADDR_W  weight memory read address. Memory read is asynchronous: data feeds the PU in the same cycle.
- `enReg`  out  1  enable for the PU input register block.
- `resAddr`  out  ADDR_W  result buffer write address.
- `resWr`  out  1  result buffer write strobe; the buffer captures the PU `result` on this cycle.
- `busy`  out  1  high while issuing or draining.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE; reset enters IDLE.
- IDLE:
  - With `start`=1 and `count`>0: latch `count`, `wBase` and `resBase`, clear the issue index, go to ISSUE.
  - With `start`=1 and `count`=0: go directly to DONE; no `enReg` and no `resWr`.
- ISSUE:
  - Each cycle drive `enReg`=1 and `wAddr`=`wBase`+idx, then increment idx.
  - After the cycle with idx=`count`-1, go to DRAIN.
  - ISSUE lasts exactly `count` consecutive cycles with no bubbles.
- Tracking: each issue cycle shifts a 1 into a `PIPE_LAT`-deep valid shift register, and each non-issue cycle shifts in a 0. A write index counts completed writes.
- Writeback:
  - When the shift-register output is 1: `resWr`=1, `resAddr`=`resBase`+wrIdx, then increment wrIdx.
  - Writes occur in issue order, one per cycle, `count` writes in total.
- DRAIN: `enReg`=0, `wAddr` holds its last value. After the cycle carrying the write for wrIdx=`count`-1, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy` is 1 in ISSUE and DRAIN only.
- Address arithmetic is modulo 2^ADDR_W; base plus index wraps silently.
- `start` outside IDLE is ignored. The latched parameters do not change mid-run.
- The PU adders are free-running and have no enable. Stale values in the tree are harmless because `resWr` is only asserted on tracked slots.

## Timing
- Reset values of all outputs: `wAddr`=0, `enReg`=0, `resAddr`=0, `resWr`=0, `busy`=0, `done`=0. Reset also clears the valid shift register and both indices.
- Reset mid-run aborts immediately. No further `resWr` is produced, even for rows already in flight, and `done` is not pulsed.
- If `start` is high in cycle 0 (IDLE):
  - Row i is issued in cycle 1+i.
  - Row i is written in cycle 1+i+`PIPE_LAT`.
  - `done` is high in cycle `count`+`PIPE_LAT`+1.
  - `busy` is high in cycles 1 .. `count`+`PIPE_LAT`.
- For `count`=0, `done` is high in cycle 1 and `busy` never rises.
- A new `start` is accepted at the earliest in the cycle after `done`, which is IDLE again.
- There is no overlap between runs and no stall input; throughput is one row per cycle.

## Test plan
- Single row: `count`=1, `wBase`=5, `resBase`=9, default `PIPE_LAT`.
  - `enReg`=1 with `wAddr`=5 in cycle 1 only.
  - `resWr`=1 with `resAddr`=9 in cycle 4.
  - `done` in cycle 5; `busy` high in cycles 1-4.
- Burst: `count`=8, `wBase`=0, `resBase`=32, with a PU model (products 3+2-1+4=8 per row) and one negative row.
  - Eight consecutive `enReg` cycles.
  - Writes in cycles 4-11 to addresses 32-39; the ReLU-clamped row is written as 0.
  - `done` in cycle 12.
- Wrap-around: `ADDR_W`=6, `count`=4, `wBase`=62, `resBase`=63.
  - `wAddr` sequence 62, 63, 0, 1.
  - `resAddr` sequence 63, 0, 1, 2.
- Zero count and ignored start:
  - `count`=0 gives `done` in cycle 1 with no `enReg` and no `resWr`.
  - A second `start` asserted during ISSUE of a `count`=5 run is ignored; exactly 5 writes occur.
- Reset mid-operation: assert `rst` in cycle 3 of a `count`=6 run.
  - From the next cycle all outputs are 0.
  - No `resWr` appears afterward and no `done` is pulsed.
  - A following `start` with `count`=2 completes normally.
- `PIPE_LAT`=1 build, `count`=3: writes in cycles 2-4 and `done` in cycle 5.
